// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences iCE40 PLL reset, qualifies lock, releases the PLL domain and retries on failure
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 25000,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_pll_lock,
    input  logic       i_retry,
    output logic       o_pll_resetb,
    output logic       o_pll_bypass,
    output logic       o_domain_rst,
    output logic       o_ready,
    output logic       o_fault,
    output logic [2:0] o_state,
    output logic [3:0] o_retry_cnt,
    output logic [7:0] o_unlock_cnt
);
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] RST_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] ST_END = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0] sync;
    logic lock_s;
    assign lock_s = sync[1];
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            sync         <= '0;
            o_retry_cnt  <= '0;
            o_unlock_cnt <= '0;
        end else begin
            sync  <= {sync[0], i_pll_lock};
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
            if (state == WAIT_LOCK && nxt == RESET_PLL)
                o_retry_cnt <= o_retry_cnt + 1'b1;
            else if (nxt == RUN || (nxt == RESET_PLL && state != RESET_PLL))
                o_retry_cnt <= '0;
            if (state == RUN && nxt == RESET_PLL && o_unlock_cnt != 8'hFF)
                o_unlock_cnt <= o_unlock_cnt + 1'b1;
        end
    end
    // A lock seen on the timeout cycle, or a drop on the final stable cycle, takes priority
    always_comb begin
        nxt = state;
        case (state)
            RESET_PLL: nxt = (cnt == RST_END) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: nxt = lock_s ? STABILIZE : (cnt != TO_END) ? WAIT_LOCK :
                             (o_retry_cnt == MAX_R) ? FAULT : RESET_PLL;
            STABILIZE: nxt = !lock_s ? WAIT_LOCK : (cnt == ST_END) ? RUN : STABILIZE;
            RUN:       nxt = lock_s ? RUN : RESET_PLL;
            FAULT:     nxt = i_retry ? RESET_PLL : FAULT;
            default:   nxt = RESET_PLL;
        endcase
    end
    always_comb begin
        o_pll_resetb = !(state == RESET_PLL || state == FAULT);
        o_pll_bypass = 1'b0;
        o_domain_rst = state != RUN;
        o_ready      = state == RUN;
        o_fault      = state == FAULT;
        o_state      = state;
    end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: random lock/retry/reset stimulus against a phase-and-countdown reference model
module tb_pll_lock_supervisor;
    localparam int RST = 4, TO = 20, ST = 8, MR = 2;
    logic i_clk = 1'b0, i_reset = 1'b1, i_pll_lock = 1'b0, i_retry = 1'b0;
    logic o_pll_resetb, o_pll_bypass, o_domain_rst, o_ready, o_fault;
    logic [2:0] o_state;
    logic [3:0] o_retry_cnt;
    logic [7:0] o_unlock_cnt;
    int checks = 0, errors = 0;
    int m_phase = 0, m_left = RST, m_retry = 0, m_unlock = 0;
    bit hist[$];
    int len;
    bit lk;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST), .MAX_RETRIES(MR)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_pll_lock(i_pll_lock), .i_retry(i_retry),
        .o_pll_resetb(o_pll_resetb), .o_pll_bypass(o_pll_bypass), .o_domain_rst(o_domain_rst),
        .o_ready(o_ready), .o_fault(o_fault), .o_state(o_state),
        .o_retry_cnt(o_retry_cnt), .o_unlock_cnt(o_unlock_cnt)
    );

    always #20 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Phases: 0 reset pulse, 1 waiting for lock, 2 qualifying, 3 running, 4 fault; m_left counts down
    task automatic model_step(input bit rst, input bit lock, input bit rty);
        bit ls;
        if (rst) begin
            m_phase = 0; m_left = RST; m_retry = 0; m_unlock = 0;
            hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
            return;
        end
        ls = hist.pop_front();
        hist.push_back(lock);
        case (m_phase)
            0: begin
                m_left--;
                if (m_left == 0) begin m_phase = 1; m_left = TO; end
            end
            1: if (ls) begin
                m_phase = 2; m_left = ST;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_retry == MR) m_phase = 4;
                    else begin m_retry++; m_phase = 0; m_left = RST; end
                end
            end
            2: if (!ls) begin
                m_phase = 1; m_left = TO;
            end else begin
                m_left--;
                if (m_left == 0) begin m_phase = 3; m_retry = 0; end
            end
            3: if (!ls) begin
                m_phase = 0; m_left = RST; m_retry = 0;
                m_unlock = (m_unlock < 255) ? m_unlock + 1 : 255;
            end
            default: if (rty) begin m_phase = 0; m_left = RST; m_retry = 0; end
        endcase
    endtask

    task automatic step(input bit rst, input bit lock, input bit rty);
        bit run, flt;
        i_reset = rst; i_pll_lock = lock; i_retry = rty;
        @(posedge i_clk);
        model_step(rst, lock, rty);
        @(negedge i_clk);
        run = m_phase == 3;
        flt = m_phase == 4;
        check("state", o_state, m_phase);
        check("retry_cnt", o_retry_cnt, m_retry);
        check("unlock_cnt", o_unlock_cnt, m_unlock);
        check("outputs", {o_pll_resetb, o_pll_bypass, o_domain_rst, o_ready, o_fault},
              {!(m_phase == 0 || flt), 1'b0, !run, run, flt});
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 100);
            lk = 1'($urandom_range(0, 1));
            for (int c = 0; c < len; c++)
                step($urandom_range(0, 299) == 0, lk, $urandom_range(0, 15) == 0);
        end
        step(1'b1, 1'b1, 1'b0);
        for (int p = 0; p < 270; p++) begin
            step(1'b0, 1'b0, 1'b0);
            repeat (20) step(1'b0, 1'b1, 1'b0);
        end
        check("unlock_saturated", o_unlock_cnt, 255);
        step(1'b1, 1'b1, 1'b1);
        check("unlock_after_reset", o_unlock_cnt, 0);
        repeat (30) step(1'b0, 1'b1, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
